// File: rtl/spidergon_packetizer_if.sv
// Handshake and flit bundle between a packet source and the spidergon packetizer.
// The master side issues requests, payload words and credit returns; the slave
// side (the packetizer) answers with ready strobes, flits and status.
interface spidergon_packetizer_if #(
  parameter int NUM_OF_NODES            = 8,
  parameter int FLIT_DATA_WIDTH         = 16,
  parameter int NUM_OF_VIRTUAL_CHANNELS = 2,
  parameter int MAX_PAYLOAD_FLITS       = 4
);
  localparam int DEST_NODE_WIDTH  = $clog2(NUM_OF_NODES);
  localparam int VC_WIDTH         = $clog2(NUM_OF_VIRTUAL_CHANNELS);
  localparam int LEN_WIDTH        = $clog2(MAX_PAYLOAD_FLITS + 1);
  localparam int FLIT_TOTAL_WIDTH = 2 + FLIT_DATA_WIDTH;

  logic                               req_valid;
  logic                               req_ready;
  logic [DEST_NODE_WIDTH-1:0]         req_dest;
  logic [VC_WIDTH-1:0]                req_vc;
  logic [LEN_WIDTH-1:0]               req_len;
  logic                               pay_valid;
  logic                               pay_ready;
  logic [FLIT_DATA_WIDTH-1:0]         pay_data;
  logic [FLIT_TOTAL_WIDTH-1:0]        flit_out;
  logic                               flit_valid;
  logic [NUM_OF_VIRTUAL_CHANNELS-1:0] credit_return;
  logic                               busy;
  logic                               credit_err;

  modport master (
    output req_valid, req_dest, req_vc, req_len,
    output pay_valid, pay_data, credit_return,
    input  req_ready, pay_ready, flit_out, flit_valid, busy, credit_err
  );

  modport slave (
    input  req_valid, req_dest, req_vc, req_len,
    input  pay_valid, pay_data, credit_return,
    output req_ready, pay_ready, flit_out, flit_valid, busy, credit_err
  );
endinterface

// File: rtl/spidergon_packetizer.sv
// Per-node injection stage: turns a packet request plus a payload word stream
// into HEAD/BODY/TAIL flits (or a single HEADER flit) for a spidergon node
// input, gated by per-VC credit counters mirroring the router VC buffer depth.
module spidergon_packetizer #(
  parameter int NUM_OF_NODES            = 8,
  parameter int FLIT_DATA_WIDTH         = 16,
  parameter int NUM_OF_VIRTUAL_CHANNELS = 2,
  parameter int NODE_ID                 = 0,
  parameter int MAX_PAYLOAD_FLITS       = 4,
  parameter int CREDITS_PER_VC          = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  spidergon_packetizer_if.slave   bus
);
  localparam int DEST_NODE_WIDTH  = $clog2(NUM_OF_NODES);
  localparam int VC_WIDTH         = $clog2(NUM_OF_VIRTUAL_CHANNELS);
  localparam int LEN_WIDTH        = $clog2(MAX_PAYLOAD_FLITS + 1);
  localparam int FLIT_TOTAL_WIDTH = 2 + FLIT_DATA_WIDTH;
  localparam int CRED_WIDTH       = $clog2(CREDITS_PER_VC + 1);
  localparam int PAD_WIDTH        = FLIT_DATA_WIDTH - VC_WIDTH - 2 * DEST_NODE_WIDTH;

  localparam logic [1:0] TYPE_HEAD   = 2'b01;
  localparam logic [1:0] TYPE_BODY   = 2'b10;
  localparam logic [1:0] TYPE_TAIL   = 2'b00;
  localparam logic [1:0] TYPE_HEADER = 2'b11;

  localparam logic [DEST_NODE_WIDTH-1:0] SRC_ID    = DEST_NODE_WIDTH'(NODE_ID);
  localparam logic [LEN_WIDTH-1:0]       MAX_LEN   = LEN_WIDTH'(MAX_PAYLOAD_FLITS);
  localparam logic [LEN_WIDTH-1:0]       LEN_ZERO  = {LEN_WIDTH{1'b0}};
  localparam logic [LEN_WIDTH-1:0]       LEN_ONE   = LEN_WIDTH'(1);
  localparam logic [CRED_WIDTH-1:0]      CRED_FULL = CRED_WIDTH'(CREDITS_PER_VC);
  localparam logic [CRED_WIDTH-1:0]      CRED_ZERO = {CRED_WIDTH{1'b0}};
  localparam logic [CRED_WIDTH-1:0]      CRED_ONE  = CRED_WIDTH'(1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HEAD    = 2'd1,
    ST_PAYLOAD = 2'd2
  } state_t;

  state_t                          r_state;
  state_t                          w_next_state;

  logic [DEST_NODE_WIDTH-1:0]      r_dest;
  logic [VC_WIDTH-1:0]             r_vc;
  logic [LEN_WIDTH-1:0]            r_len;
  logic [LEN_WIDTH-1:0]            r_remaining;
  logic [CRED_WIDTH-1:0]           r_credit [NUM_OF_VIRTUAL_CHANNELS];
  logic                            r_credit_err;
  logic [FLIT_TOTAL_WIDTH-1:0]     r_flit_out;
  logic                            r_flit_valid;

  logic                            w_req_ready;
  logic                            w_pay_ready;
  logic                            w_accept;
  logic                            w_issue;
  logic                            w_credit_ok;
  logic [1:0]                      w_flit_type;
  logic [FLIT_DATA_WIDTH-1:0]      w_flit_data;
  logic [FLIT_DATA_WIDTH-1:0]      w_route_field;
  logic [LEN_WIDTH-1:0]            w_len_clamped;
  logic [NUM_OF_VIRTUAL_CHANNELS-1:0] w_dec;
  logic [NUM_OF_VIRTUAL_CHANNELS-1:0] w_ovf;

  // Issue decisions look only at the registered counter of the packet's VC,
  // so a same-cycle credit return never enables a send.
  assign w_credit_ok   = (r_credit[r_vc] != CRED_ZERO);
  assign w_accept      = w_req_ready & bus.req_valid;
  assign w_len_clamped = (bus.req_len > MAX_LEN) ? MAX_LEN : bus.req_len;
  assign w_route_field = {r_vc, r_dest, SRC_ID, {PAD_WIDTH{1'b0}}};

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic: a packet ends on the HEADER issue or the TAIL handshake.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_next_state = ST_HEAD;
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      ST_HEAD: begin
        if (w_issue) begin
          w_next_state = (r_len == LEN_ZERO) ? ST_IDLE : ST_PAYLOAD;
        end else begin
          w_next_state = ST_HEAD;
        end
      end
      ST_PAYLOAD: begin
        if (w_issue && (r_remaining == LEN_ONE)) begin
          w_next_state = ST_IDLE;
        end else begin
          w_next_state = ST_PAYLOAD;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Output/issue logic: handshake strobes and the flit to be registered.
  always_comb begin
    w_req_ready = 1'b0;
    w_pay_ready = 1'b0;
    w_issue     = 1'b0;
    w_flit_type = TYPE_TAIL;
    w_flit_data = {FLIT_DATA_WIDTH{1'b0}};
    case (r_state)
      ST_IDLE: begin
        w_req_ready = ~reset;
      end
      ST_HEAD: begin
        if (w_credit_ok) begin
          w_issue     = 1'b1;
          w_flit_type = (r_len == LEN_ZERO) ? TYPE_HEADER : TYPE_HEAD;
          w_flit_data = w_route_field;
        end else begin
          w_issue     = 1'b0;
        end
      end
      ST_PAYLOAD: begin
        w_pay_ready = w_credit_ok & ~reset;
        if (w_pay_ready && bus.pay_valid) begin
          w_issue     = 1'b1;
          w_flit_type = (r_remaining == LEN_ONE) ? TYPE_TAIL : TYPE_BODY;
          w_flit_data = bus.pay_data;
        end else begin
          w_issue     = 1'b0;
        end
      end
      default: begin
        w_req_ready = 1'b0;
      end
    endcase
  end

  // Packet context: latch the request and count down remaining payload words.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_dest      <= {DEST_NODE_WIDTH{1'b0}};
      r_vc        <= {VC_WIDTH{1'b0}};
      r_len       <= LEN_ZERO;
      r_remaining <= LEN_ZERO;
    end else if (w_accept) begin
      r_dest      <= bus.req_dest;
      r_vc        <= bus.req_vc;
      r_len       <= w_len_clamped;
    end else if (w_issue && (r_state == ST_HEAD)) begin
      r_remaining <= r_len;
    end else if (w_issue && (r_state == ST_PAYLOAD)) begin
      r_remaining <= r_remaining - LEN_ONE;
    end
  end

  // Registered flit output: valid the cycle after the issue decision.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_flit_out   <= {FLIT_TOTAL_WIDTH{1'b0}};
      r_flit_valid <= 1'b0;
    end else begin
      r_flit_valid <= w_issue;
      r_flit_out   <= w_issue ? {w_flit_type, w_flit_data} : {FLIT_TOTAL_WIDTH{1'b0}};
    end
  end

  // Per-VC send/return decode; a return at full count with no send overflows.
  always_comb begin
    w_dec = {NUM_OF_VIRTUAL_CHANNELS{1'b0}};
    w_ovf = {NUM_OF_VIRTUAL_CHANNELS{1'b0}};
    for (int v = 0; v < NUM_OF_VIRTUAL_CHANNELS; v++) begin
      w_dec[v] = w_issue & (r_vc == VC_WIDTH'(v));
      w_ovf[v] = bus.credit_return[v] & ~w_dec[v] & (r_credit[v] == CRED_FULL);
    end
  end

  // Credit counters: send decrements, return increments, both cancel, full saturates.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int v = 0; v < NUM_OF_VIRTUAL_CHANNELS; v++) begin
        r_credit[v] <= CRED_FULL;
      end
    end else begin
      for (int v = 0; v < NUM_OF_VIRTUAL_CHANNELS; v++) begin
        if (w_dec[v] && !bus.credit_return[v]) begin
          r_credit[v] <= r_credit[v] - CRED_ONE;
        end else if (bus.credit_return[v] && !w_dec[v] && (r_credit[v] != CRED_FULL)) begin
          r_credit[v] <= r_credit[v] + CRED_ONE;
        end else begin
          r_credit[v] <= r_credit[v];
        end
      end
    end
  end

  // Sticky credit overflow flag, cleared only by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_credit_err <= 1'b0;
    end else begin
      r_credit_err <= r_credit_err | (|w_ovf);
    end
  end

  assign bus.req_ready  = w_req_ready;
  assign bus.pay_ready  = w_pay_ready;
  assign bus.flit_out   = r_flit_out;
  assign bus.flit_valid = r_flit_valid;
  assign bus.busy       = (r_state != ST_IDLE);
  assign bus.credit_err = r_credit_err;
endmodule
